// File: rtl/cpu_bus_sequencer_pkg.sv
// cpu_bus_sequencer_pkg: addressing-mode codes, sequencer states and address-select codes
package cpu_bus_sequencer_pkg;
  localparam logic [4:0] ADR_INVAL     = 5'd0;
  localparam logic [4:0] ADR_IMPL      = 5'd1;
  localparam logic [4:0] ADR_ACCUM     = 5'd2;
  localparam logic [4:0] ADR_IMM       = 5'd3;
  localparam logic [4:0] ADR_ZPG       = 5'd4;
  localparam logic [4:0] ADR_ZPG_X_Y   = 5'd5;
  localparam logic [4:0] ADR_ABS       = 5'd6;
  localparam logic [4:0] ADR_ABS_X_Y   = 5'd7;
  localparam logic [4:0] ADR_ZPG_RMW   = 5'd8;
  localparam logic [4:0] ADR_ZPG_X_RMW = 5'd9;
  localparam logic [4:0] ADR_ABS_RMW   = 5'd10;
  localparam logic [4:0] ADR_ABS_X_RMW = 5'd11;
  localparam logic [4:0] ADR_REL       = 5'd12;
  localparam logic [4:0] ADR_JSR       = 5'd13;
  localparam logic [4:0] ADR_JMP       = 5'd14;
  localparam logic [4:0] ADR_IND       = 5'd15;
  localparam logic [4:0] ADR_STACK     = 5'd16;
  localparam logic [1:0] ASEL_PC  = 2'b00;
  localparam logic [1:0] ASEL_ZP  = 2'b01;
  localparam logic [1:0] ASEL_ABS = 2'b10;
  typedef enum logic [3:0] {
    SEQ_FETCH, SEQ_OPER, SEQ_ADDRH, SEQ_INDEX, SEQ_FIXUP, SEQ_ACCESS,
    SEQ_RMW_MOD, SEQ_RMW_WR, SEQ_BR_TAKE, SEQ_BR_FIX, SEQ_HALT
  } seq_e;
  function automatic logic is_zp(input logic [4:0] m);
    return m inside {ADR_ZPG, ADR_ZPG_X_Y, ADR_ZPG_RMW, ADR_ZPG_X_RMW};
  endfunction
  function automatic logic is_abs(input logic [4:0] m);
    return m inside {ADR_ABS, ADR_ABS_X_Y, ADR_ABS_RMW, ADR_ABS_X_RMW};
  endfunction
  function automatic logic is_rmw(input logic [4:0] m);
    return m inside {ADR_ZPG_RMW, ADR_ZPG_X_RMW, ADR_ABS_RMW, ADR_ABS_X_RMW};
  endfunction
endpackage

// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: per-cycle bus sequencing of 6502 instructions for the non-stack addressing modes
module cpu_bus_sequencer
  import cpu_bus_sequencer_pkg::*;
#(
  parameter seq_e RESET_STATE = SEQ_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] adr_mode,
  input  logic       from_mem,
  input  logic       to_mem,
  input  logic       branch_taken,
  input  logic       page_cross,
  input  logic       ready,
  output logic       sync,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       adl_load,
  output logic       adh_load,
  output logic       index_add,
  output logic       adh_fix,
  output logic       pc_rel,
  output logic       pch_fix,
  output logic [1:0] addr_sel,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       wr_alu,
  output logic       exec,
  output logic       fault
);
  seq_e state_q, state_d;
  logic carry_q, carry_d, go, stb, simple, mem_op, valid, rmw, zp, abs_x, ld, bit_cls;
  assign simple  = adr_mode inside {ADR_IMPL, ADR_ACCUM, ADR_IMM};
  assign mem_op  = is_zp(adr_mode) | is_abs(adr_mode);
  assign valid   = simple | mem_op | (adr_mode == ADR_REL);
  assign rmw     = is_rmw(adr_mode);
  assign zp      = is_zp(adr_mode);
  assign abs_x   = adr_mode inside {ADR_ABS_X_Y, ADR_ABS_X_RMW};
  assign ld      = from_mem & ~to_mem;
  assign bit_cls = ~from_mem & ~to_mem;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
    end
  end
  // A stalled read cycle (go=0) holds both the state and the registered carry.
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    if (go) begin
      case (state_q)
        SEQ_FETCH:   state_d = SEQ_OPER;
        SEQ_OPER:    state_d = simple ? SEQ_FETCH
                             : adr_mode == ADR_REL ? (branch_taken ? SEQ_BR_TAKE : SEQ_FETCH)
                             : adr_mode inside {ADR_ZPG, ADR_ZPG_RMW} ? SEQ_ACCESS
                             : zp ? SEQ_INDEX
                             : is_abs(adr_mode) ? SEQ_ADDRH : SEQ_HALT;
        SEQ_ADDRH: begin
          state_d = (adr_mode == ADR_ABS_X_RMW || (adr_mode == ADR_ABS_X_Y && (page_cross || to_mem)))
                    ? SEQ_FIXUP : SEQ_ACCESS;
          carry_d = page_cross;
        end
        SEQ_INDEX:   state_d = SEQ_ACCESS;
        SEQ_FIXUP:   state_d = SEQ_ACCESS;
        SEQ_ACCESS:  state_d = rmw ? SEQ_RMW_MOD : SEQ_FETCH;
        SEQ_RMW_MOD: state_d = SEQ_RMW_WR;
        SEQ_RMW_WR:  state_d = SEQ_FETCH;
        SEQ_BR_TAKE: state_d = page_cross ? SEQ_BR_FIX : SEQ_FETCH;
        SEQ_BR_FIX:  state_d = SEQ_FETCH;
        default:     state_d = SEQ_HALT;
      endcase
    end
  end
  always_comb begin
    mem_rd    = ~rst & ((state_q inside {SEQ_FETCH, SEQ_ADDRH, SEQ_INDEX, SEQ_FIXUP, SEQ_BR_TAKE, SEQ_BR_FIX})
                | (state_q == SEQ_OPER & valid) | (state_q == SEQ_ACCESS & (rmw | ld | bit_cls)));
    go        = ready | ~mem_rd;
    stb       = ~rst & go;
    mem_we    = ~rst & ((state_q == SEQ_ACCESS & ~rmw & to_mem) | (state_q inside {SEQ_RMW_MOD, SEQ_RMW_WR}));
    wr_alu    = ~rst & (state_q == SEQ_RMW_WR);
    sync      = ~rst & (state_q == SEQ_FETCH);
    ir_load   = stb & (state_q == SEQ_FETCH);
    pc_inc    = stb & ((state_q inside {SEQ_FETCH, SEQ_ADDRH})
                | (state_q == SEQ_OPER & valid & ~(adr_mode inside {ADR_IMPL, ADR_ACCUM})));
    adl_load  = stb & (state_q == SEQ_OPER) & mem_op;
    adh_load  = stb & (state_q == SEQ_ADDRH);
    index_add = stb & ((state_q == SEQ_ADDRH & abs_x) | state_q == SEQ_INDEX);
    adh_fix   = stb & (state_q == SEQ_FIXUP) & carry_q;
    pc_rel    = stb & (state_q == SEQ_BR_TAKE);
    pch_fix   = stb & (state_q == SEQ_BR_FIX);
    exec      = stb & ((state_q == SEQ_OPER & simple) | (state_q == SEQ_ACCESS & ~rmw) | state_q == SEQ_RMW_MOD);
    addr_sel  = rst ? ASEL_PC
              : state_q == SEQ_INDEX ? ASEL_ZP
              : state_q == SEQ_FIXUP ? ASEL_ABS
              : state_q inside {SEQ_ACCESS, SEQ_RMW_MOD, SEQ_RMW_WR} ? (zp ? ASEL_ZP : ASEL_ABS)
              : ASEL_PC;
    fault     = state_q == SEQ_HALT;
  end
endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb_cpu_bus_sequencer: directed per-instruction cycle checks of the bus sequencer
module tb_cpu_bus_sequencer;
  import cpu_bus_sequencer_pkg::*;
  logic clk = 0, rst = 1, from_mem = 0, to_mem = 0, branch_taken = 0, page_cross = 0, ready = 1;
  logic [4:0] adr_mode = ADR_IMPL;
  logic sync, ir_load, pc_inc, adl_load, adh_load, index_add, adh_fix, pc_rel, pch_fix;
  logic mem_rd, mem_we, wr_alu, exec, fault;
  logic [1:0] addr_sel;
  int n_chk = 0, n_fail = 0;
  int cyc, n_exec, n_we, n_fix, n_rel, n_pch, n_idx;
  logic exec_l[16], we_l[16], wa_l[16], rd_l[16];
  logic [1:0] as_l[16];
  cpu_bus_sequencer dut (
    .clk(clk), .rst(rst), .adr_mode(adr_mode), .from_mem(from_mem), .to_mem(to_mem),
    .branch_taken(branch_taken), .page_cross(page_cross), .ready(ready), .sync(sync),
    .ir_load(ir_load), .pc_inc(pc_inc), .adl_load(adl_load), .adh_load(adh_load),
    .index_add(index_add), .adh_fix(adh_fix), .pc_rel(pc_rel), .pch_fix(pch_fix),
    .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_we(mem_we), .wr_alu(wr_alu), .exec(exec),
    .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Starts in a FETCH cycle; runs until the next FETCH, logging outputs per cycle.
  task automatic run(input logic [4:0] m, input logic fm, input logic tm, input logic bt,
                     input logic pc, input int st_c, input int st_n);
    adr_mode = m; from_mem = fm; to_mem = tm; branch_taken = bt; page_cross = pc;
    cyc = 0; n_exec = 0; n_we = 0; n_fix = 0; n_rel = 0; n_pch = 0; n_idx = 0;
    do begin
      ready = !(cyc >= st_c && cyc < st_c + st_n);
      #1;
      exec_l[cyc] = exec; we_l[cyc] = mem_we; wa_l[cyc] = wr_alu; rd_l[cyc] = mem_rd; as_l[cyc] = addr_sel;
      n_exec += int'(exec); n_we += int'(mem_we); n_fix += int'(adh_fix);
      n_rel += int'(pc_rel); n_pch += int'(pch_fix); n_idx += int'(index_add);
      cyc++;
      @(posedge clk); #1;
    end while (!sync && cyc < 16);
    ready = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", mem_rd, 0);
    check("rst_asel", addr_sel, ASEL_PC);
    check("rst_sync", sync, 0);
    rst = 0;
    #1;
    check("rst_fault", fault, 0);
    check("fetch_sync", sync, 1);
    check("fetch_irl", ir_load, 1);
    run(ADR_IMM, 1, 0, 0, 0, 0, 0);
    check("imm_cyc", cyc, 2);
    check("imm_exec_c2", exec_l[1], 1);
    check("imm_nexec", n_exec, 1);
    check("imm_sync_c3", sync, 1);
    run(ADR_ABS_X_Y, 1, 0, 0, 1, 0, 0);
    check("absx_x_cyc", cyc, 5);
    check("absx_x_fix", n_fix, 1);
    check("absx_x_fixaddr", as_l[3], ASEL_ABS);
    check("absx_x_idx", n_idx, 1);
    run(ADR_ABS_X_Y, 1, 0, 0, 0, 0, 0);
    check("absx_nx_cyc", cyc, 4);
    check("absx_nx_fix", n_fix, 0);
    check("absx_nx_exec", n_exec, 1);
    run(ADR_ABS_X_Y, 0, 1, 0, 0, 0, 0);
    check("stax_cyc", cyc, 5);
    check("stax_fix", n_fix, 0);
    check("stax_we", n_we, 1);
    check("stax_we_c5", we_l[4], 1);
    run(ADR_ZPG_RMW, 0, 0, 0, 0, 0, 0);
    check("inc_cyc", cyc, 5);
    check("inc_nexec", n_exec, 1);
    check("inc_rd_asel", as_l[2], ASEL_ZP);
    check("inc_rd", rd_l[2], 1);
    check("inc_we1", we_l[3], 1);
    check("inc_wa1", wa_l[3], 0);
    check("inc_we2", we_l[4], 1);
    check("inc_wa2", wa_l[4], 1);
    check("inc_we_asel", as_l[4], ASEL_ZP);
    run(ADR_REL, 0, 0, 1, 0, 0, 0);
    check("bne_t_cyc", cyc, 3);
    check("bne_t_rel", n_rel, 1);
    check("bne_t_pch", n_pch, 0);
    run(ADR_REL, 0, 0, 1, 1, 0, 0);
    check("bne_tx_cyc", cyc, 4);
    check("bne_tx_pch", n_pch, 1);
    run(ADR_REL, 0, 0, 0, 1, 0, 0);
    check("bne_nt_cyc", cyc, 2);
    check("bne_nt_rel", n_rel, 0);
    run(ADR_IMPL, 0, 0, 0, 0, 0, 0);
    check("impl_cyc", cyc, 2);
    check("impl_dummy_rd", rd_l[1], 1);
    run(ADR_ZPG, 1, 0, 0, 0, 0, 0);
    check("zpg_cyc", cyc, 3);
    run(ADR_ZPG_X_Y, 1, 0, 0, 0, 0, 0);
    check("zpgx_cyc", cyc, 4);
    check("zpgx_idx", n_idx, 1);
    check("zpgx_asel", as_l[2], ASEL_ZP);
    run(ADR_ABS, 1, 0, 0, 0, 0, 0);
    check("abs_cyc", cyc, 4);
    check("abs_asel", as_l[3], ASEL_ABS);
    run(ADR_ZPG_X_RMW, 0, 0, 0, 0, 0, 0);
    check("zpgx_rmw_cyc", cyc, 6);
    run(ADR_ABS_RMW, 0, 0, 0, 0, 0, 0);
    check("abs_rmw_cyc", cyc, 6);
    run(ADR_ABS_X_RMW, 0, 0, 0, 0, 0, 0);
    check("absx_rmw_cyc", cyc, 7);
    check("absx_rmw_we", n_we, 2);
    run(ADR_ZPG, 1, 0, 0, 0, 2, 3);
    check("rdy_cyc", cyc, 6);
    check("rdy_nexec", n_exec, 1);
    check("rdy_exec_c6", exec_l[5], 1);
    check("rdy_stall_exec", exec_l[4], 0);
    check("rdy_stall_rd", rd_l[3], 1);
    check("rdy_stall_asel", as_l[4], ASEL_ZP);
    adr_mode = ADR_JSR; from_mem = 0; to_mem = 0;
    @(posedge clk); #1;
    check("jsr_oper_inc", pc_inc, 0);
    @(posedge clk); #1;
    check("jsr_fault_c3", fault, 1);
    check("jsr_halt_rd", mem_rd, 0);
    check("jsr_halt_sync", sync, 0);
    repeat (2) @(posedge clk);
    #1;
    check("jsr_fault_sticky", fault, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("jsr_rst_fault", fault, 0);
    check("jsr_rst_sync", sync, 1);
    adr_mode = ADR_ABS; to_mem = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_adh_load", adh_load, 1);
    rst = 1;
    #1;
    check("mid_rst_rd", mem_rd, 0);
    check("mid_rst_adh", adh_load, 0);
    check("mid_rst_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("mid_after_sync", sync, 1);
    check("mid_after_we", mem_we, 0);
    check("mid_after_fault", fault, 0);
    run(ADR_IMM, 1, 0, 0, 0, 0, 0);
    check("mid_then_imm_cyc", cyc, 2);
    check("mid_then_imm_we", n_we, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
